ray_aabb_hit_collector: RTL
===========================

RAY_AABB_HIT_COLLECTOR -- requirements
Module: ray_aabb_hit_collector

Interface
REQ-001 Parameter CMP_LAT, default 3: cycles from operand issue to the comparator `less` outputs being valid; legal range 1..8.
REQ-002 Parameter ID_W, default 8: width of the ray tag.
REQ-003 Parameter DEPTH, default 4: result FIFO entries; power of two, 2..16.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 issue_valid  in  1  operands for one ray were presented to both comparators this cycle.
REQ-007 issue_id  in  ID_W  tag of the issued ray.
REQ-008 issue_ready  out  1  block can accept an issue this cycle.
REQ-009 less_nf  in  1  comparator result "tnear < tfar".
REQ-010 less_fz  in  1  comparator result "tfar < 0".
REQ-011 hit_valid  out  1  FIFO head holds a result.
REQ-012 hit_ready  in  1  consumer accepts the head.
REQ-013 hit  out  1  head hit flag.
REQ-014 hit_id  out  ID_W  head ray tag.
REQ-015 hit_count  out  16  saturating count of delivered hits.
REQ-016 err  out  1  sticky protocol-violation flag.

Function
REQ-017 Issue accepted iff issue_valid & issue_ready; an accepted issue enters a CMP_LAT-stage shift register holding {valid, id}.
REQ-018 issue_ready is a registered-state function: high iff fifo_count + inflight < DEPTH, where inflight is the number of valid delay-line stages.
REQ-019 issue_valid while issue_ready is low is ignored (no delay-line entry) and sets err.
REQ-020 When the last delay stage is valid, less_nf and less_fz are sampled that cycle, and {hit = less_nf & ~less_fz, id} is pushed into the FIFO.
REQ-021 Results leave the FIFO in issue order; no reordering and no drops when the issuer obeys issue_ready.
REQ-022 hit_valid = (fifo_count != 0); hit and hit_id show the head entry combinationally from FIFO storage.
REQ-023 A pop occurs iff hit_valid & hit_ready; on a pop with hit = 1, hit_count increments, saturating at 16'hFFFF.
REQ-024 A simultaneous push and pop leaves fifo_count unchanged; with an empty FIFO, a pushed entry appears at hit_valid the following cycle (no bypass).
REQ-025 Credit freed by a pop is reflected in issue_ready on the next cycle only.
REQ-026 A push with the FIFO full (reachable only after an err event) drops the entry and sets err.
REQ-027 Latency: accepted issue at cycle t gives hit_valid at t+CMP_LAT+1 when the FIFO is empty.
REQ-028 FIFO pointers are log2(DEPTH) bits wide, wrap modulo DEPTH, and use a separate count of log2(DEPTH)+1 bits.
REQ-029 hit_ready while hit_valid is low has no effect.

Reset
REQ-030 rst low asynchronously clears the delay-line valids, FIFO pointers and count, hit_count and err; outputs then read issue_ready = 1, hit_valid = 0, hit = 0, hit_id = 0, hit_count = 0, err = 0.
REQ-031 Reset asserted mid-operation discards all in-flight and queued results; comparator outputs arriving after reset release with no matching valid stage are ignored.
REQ-032 FIFO data storage needs no reset.

Verification
REQ-033 Single ray: issue id=0x05 at t0, drive less_nf = 1 and less_fz = 0 at t0+3 -> hit_valid = 1 at t0+4 with hit = 1, hit_id = 0x05; pop -> hit_count = 1.
REQ-034 Miss cases: {less_nf, less_fz} = {0,0} for id 1, {1,1} for id 2 -> two results with hit = 0, in order 1, 2; hit_count stays 0.
REQ-035 Backpressure: hit_ready = 0, issue every cycle -> exactly 4 issues accepted, issue_ready = 0 thereafter, err = 0; one pop -> issue_ready = 1 the next cycle.
REQ-036 Violation: drive issue_valid while issue_ready = 0 -> err = 1 and stays set; no extra result appears.
REQ-037 Reset mid-flight: 2 rays in the delay line and 2 in the FIFO, pulse rst low -> hit_valid = 0 and issue_ready = 1 immediately; no stale results afterwards.
REQ-038 Saturation: preload hit_count near 16'hFFFF via 65537 hit pops -> hit_count holds at 16'hFFFF.

Source files
------------

// File: rtl/ray_aabb_hit_collector.sv
// ray_aabb_hit_collector
// Tags each issued ray through a delay line that matches the comparator
// pipeline latency. It combines the two comparator flags into a hit/miss
// result and queues results in issue order. issue_ready is driven by credits,
// so an obedient issuer can never overflow the result queue.
module ray_aabb_hit_collector #(
    parameter int CMP_LAT = 3,
    parameter int ID_W    = 8,
    parameter int DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [ID_W-1:0] issue_id,
    output logic            issue_ready,
    input  logic            less_nf,
    input  logic            less_fz,
    output logic            hit_valid,
    input  logic            hit_ready,
    output logic            hit,
    output logic [ID_W-1:0] hit_id,
    output logic [15:0]     hit_count,
    output logic            err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int INF_W = $clog2(CMP_LAT + 1);
    localparam int OCC_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

    // Saturating increment for the delivered-hit counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Delay line: one {valid, id} pair per comparator stage.
    logic [CMP_LAT-1:0] vld_p;
    logic [ID_W-1:0]    id_p [CMP_LAT];
    logic [INF_W-1:0]   inflight;

    // Result FIFO.
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_count;
    logic               mem_hit [DEPTH];
    logic [ID_W-1:0]    mem_id  [DEPTH];

    logic               accept;
    logic               push;
    logic               full;
    logic               wr_en;
    logic               pop;
    logic               new_hit;
    logic [OCC_W-1:0]   occupancy;

    assign accept  = issue_valid & issue_ready;
    assign push    = vld_p[CMP_LAT-1];
    assign full    = (fifo_count == CNT_W'(DEPTH));
    assign wr_en   = push & ~full;
    assign pop     = hit_valid & hit_ready;
    assign new_hit = less_nf & ~less_fz;

    // ---- issue -> delay line stage boundary ----

    // Valid bits shift toward the FIFO. They are cleared on reset, so comparator
    // results that arrive afterwards have no matching stage and are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p <= '0;
        end else begin
            vld_p <= (vld_p << 1) | CMP_LAT'(accept);
        end
    end

    // Ray tags travel alongside their valid bits. This is data only, so it has no reset.
    always_ff @(posedge clk) begin
        id_p[0] <= issue_id;
        for (int i = 1; i < CMP_LAT; i++) begin
            id_p[i] <= id_p[i-1];
        end
    end

    // Count the rays still in flight. These rays already hold a FIFO credit.
    always_comb begin
        inflight = INF_W'($countones(vld_p));
    end

    // ---- delay line -> result FIFO stage boundary ----

    // Write the combined comparator verdict and its tag at the tail.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_hit[wr_ptr] <= new_hit;
            mem_id[wr_ptr]  <= id_p[CMP_LAT-1];
        end
    end

    // Pointers wrap naturally at DEPTH, and a separate count tells full from empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Count delivered hits, saturating at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count <= '0;
        end else if (pop && hit) begin
            hit_count <= sat_inc16(hit_count);
        end
    end

    // Sticky flag. It is set by an issue without credit, or by a result that finds the FIFO full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if ((issue_valid && !issue_ready) || (push && full)) begin
            err <= 1'b1;
        end
    end

    // ---- FIFO head -> consumer ----

    // Credit check uses registered state only. A pop therefore frees credit one cycle later.
    always_comb begin
        occupancy   = OCC_W'(fifo_count) + OCC_W'(inflight);
        issue_ready = (occupancy < OCC_W'(DEPTH));
    end

    // The head is shown straight from storage. It is masked while the FIFO is empty,
    // so the unreset storage never reaches the outputs.
    always_comb begin
        hit_valid = (fifo_count != '0);
        hit       = hit_valid & mem_hit[rd_ptr];
        hit_id    = hit_valid ? mem_id[rd_ptr] : '0;
    end

endmodule
